// File: rtl/reset_pulse_pkg.sv
// Shared types and helpers for the reset-request pulse generator.
package reset_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } chan_state_e;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  localparam int MAX_PACK_W = 256;

  // Extract the w-bit field for channel ch from a packed per-channel parameter.
  function automatic logic [31:0] chan_field(input logic [MAX_PACK_W-1:0] vec,
                                             input int ch, input int w);
    logic [MAX_PACK_W-1:0] mask;
    mask = (MAX_PACK_W'(1) << w) - MAX_PACK_W'(1);
    return 32'((vec >> (ch * w)) & mask);
  endfunction

endpackage

// File: rtl/reset_pulse_chan.sv
// One reset-request channel: synchroniser, edge detect, pulse/holdoff FSM, sticky drop bit.
//   state      | meaning
//   ST_IDLE    | waiting for a trigger, output inactive
//   ST_PULSE   | output active, counter runs down the pulse length
//   ST_HOLDOFF | output inactive, counter runs down, triggers refused
module reset_pulse_chan
  import reset_pulse_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_W       = 6,
  parameter logic [CNT_W-1:0] PULSE_LEN   = 6,
  parameter logic [1:0]       EDGE_MODE   = EDGE_RISE,
  parameter logic             RETRIGGER   = 1'b0,
  parameter logic             OUT_POL     = 1'b1,
  parameter logic [CNT_W-1:0] HOLDOFF     = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signal_i,
  input  logic sw_trig_i,
  input  logic armed_i,
  input  logic status_clr_i,
  output logic pulse_o,
  output logic busy_o,
  output logic dropped_o
);

  // A zero pulse length behaves as a single-cycle pulse.
  localparam logic [CNT_W-1:0] LOAD_PULSE = (PULSE_LEN == '0) ? '0 : PULSE_LEN - 1'b1;
  localparam logic [CNT_W-1:0] LOAD_HOLD  = HOLDOFF - 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;
  logic                   edge_hit;
  logic                   trig;
  chan_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse_q, busy_q, dropped_q;
  logic                   drop_set;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_hit = 1'b0;
    case (EDGE_MODE)
      EDGE_RISE: edge_hit = sync_out & ~prev_q;
      EDGE_FALL: edge_hit = ~sync_out & prev_q;
      EDGE_BOTH: edge_hit = sync_out ^ prev_q;
      default:   edge_hit = 1'b0;
    endcase
  end

  assign trig = sw_trig_i | (armed_i & edge_hit);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drop_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_PULSE;
          cnt_d   = LOAD_PULSE;
        end
      end
      ST_PULSE: begin
        if (trig && RETRIGGER) begin
          cnt_d = LOAD_PULSE;
        end else begin
          drop_set = trig;
          if (cnt_q == '0) begin
            if (HOLDOFF != '0) begin
              state_d = ST_HOLDOFF;
              cnt_d   = LOAD_HOLD;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_HOLDOFF: begin
        drop_set = trig;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pulse_q   <= OUT_POL;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], signal_i};
      prev_q    <= sync_out;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= (state_d == ST_PULSE) ^ OUT_POL;
      busy_q    <= (state_d != ST_IDLE);
      dropped_q <= drop_set | (dropped_q & ~status_clr_i);
    end
  end

  assign pulse_o   = pulse_q;
  assign busy_o    = busy_q;
  assign dropped_o = dropped_q;

endmodule

// File: rtl/reset_pulse_ctrl.sv
// Multi-channel reset-request pulse generator; holds the shared arm counter and
// slices the packed per-channel parameters.
module reset_pulse_ctrl
  import reset_pulse_pkg::*;
#(
  parameter int                      NUM_CH      = 3,
  parameter int                      SYNC_STAGES = 2,
  parameter int                      CNT_W       = 6,
  parameter logic [NUM_CH*CNT_W-1:0] PULSE_LEN   = {6'd32, 6'd2, 6'd6},
  parameter logic [NUM_CH*2-1:0]     EDGE_MODE   = {3{2'b01}},
  parameter logic [NUM_CH-1:0]       RETRIGGER   = 3'b000,
  parameter logic [NUM_CH-1:0]       OUT_POL     = 3'b111,
  parameter logic [CNT_W-1:0]        HOLDOFF     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] signal_in,
  input  logic [NUM_CH-1:0] sw_trig,
  input  logic              status_clr,
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] dropped
);

  // Edge detection stays off until the synchronisers and previous-value
  // registers hold real samples, so a level already high at release is ignored.
  localparam int ARM_CYCLES = SYNC_STAGES + 1;

  logic [2:0] arm_cnt_q;
  logic       armed;

  assign armed = (arm_cnt_q == 3'(ARM_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt_q <= '0;
    end else if (!armed) begin
      arm_cnt_q <= arm_cnt_q + 3'd1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    localparam logic [CNT_W-1:0] CH_LEN  =
      CNT_W'(chan_field(MAX_PACK_W'(PULSE_LEN), ch, CNT_W));
    localparam logic [1:0]       CH_MODE =
      2'(chan_field(MAX_PACK_W'(EDGE_MODE), ch, 2));

    reset_pulse_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .PULSE_LEN  (CH_LEN),
      .EDGE_MODE  (CH_MODE),
      .RETRIGGER  (RETRIGGER[ch]),
      .OUT_POL    (OUT_POL[ch]),
      .HOLDOFF    (HOLDOFF)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .signal_i    (signal_in[ch]),
      .sw_trig_i   (sw_trig[ch]),
      .armed_i     (armed),
      .status_clr_i(status_clr),
      .pulse_o     (pulse_out[ch]),
      .busy_o      (busy[ch]),
      .dropped_o   (dropped[ch])
    );
  end

endmodule

// File: tb/tb_reset_pulse_ctrl.sv
// Scoreboard bench: two configurations of reset_pulse_ctrl; expected pulses are
// queued by the stimulus and matched by a pulse monitor sampling on the falling edge.
module tb_reset_pulse_ctrl;

  localparam logic [2:0] POL_A = 3'b111;
  localparam logic [2:0] POL_B = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sig_a, sw_a, sig_b, sw_b;
  logic       clr_a, clr_b;
  logic [2:0] pulse_out_a, busy_a, dropped_a;
  logic [2:0] pulse_out_b, busy_b, dropped_b;

  always #5 clk = ~clk;

  reset_pulse_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .signal_in(sig_a), .sw_trig(sw_a), .status_clr(clr_a),
    .pulse_out(pulse_out_a), .busy(busy_a), .dropped(dropped_a)
  );

  reset_pulse_ctrl #(
    .RETRIGGER(3'b001),
    .HOLDOFF  (6'd4),
    .EDGE_MODE({2'b01, 2'b11, 2'b01}),
    .OUT_POL  (POL_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .signal_in(sig_b), .sw_trig(sw_b), .status_clr(clr_b),
    .pulse_out(pulse_out_b), .busy(busy_b), .dropped(dropped_b)
  );

  typedef struct {
    int idx;
    int start;
    int width;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;
  logic [5:0] mon_en = '0;
  logic [5:0] was = '0;
  int         start_c [6];
  logic [5:0] act_v;

  assign act_v = {pulse_out_b ^ POL_B, pulse_out_a ^ POL_A};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor indices: 0..2 = dut_a channels, 3..5 = dut_b channels.
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (!mon_en[i]) begin
        was[i] = 1'b0;
      end else if (act_v[i] && !was[i]) begin
        start_c[i] = cyc;
        was[i] = 1'b1;
      end else if (!act_v[i] && was[i]) begin
        int found;
        found = -1;
        was[i] = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
          if (found < 0 && exp_q[j].idx == i) found = j;
        end
        n_checks++;
        if (found < 0) begin
          n_err++;
          $display("FAIL pulse_unexpected idx=%0d: got start=%0d width=%0d, required none",
                   i, start_c[i], cyc - start_c[i]);
        end else begin
          if (exp_q[found].start != start_c[i] || exp_q[found].width != cyc - start_c[i]) begin
            n_err++;
            $display("FAIL pulse idx=%0d: got start=%0d width=%0d, required start=%0d width=%0d",
                     i, start_c[i], cyc - start_c[i], exp_q[found].start, exp_q[found].width);
          end
          exp_q.delete(found);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int start, input int width);
    exp_t e;
    e.idx = idx; e.start = start; e.width = width;
    exp_q.push_back(e);
  endtask

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    sig_a = 3'b111; sw_a = '0; clr_a = 1'b0;
    sig_b = 3'b000; sw_b = '0; clr_b = 1'b0;
    repeat (3) tick();
    chk3("reset_pulse_a", pulse_out_a, 3'b111);
    chk3("reset_pulse_b", pulse_out_b, 3'b101);
    chk3("reset_busy_a", busy_a, 3'b000);
    chk3("reset_dropped_a", dropped_a, 3'b000);

    // Release with inputs already high: no pulses may appear.
    mon_en = 6'h3f;
    rst_n = 1'b1;
    repeat (10) tick();
    chk3("release_pulse_a", pulse_out_a, 3'b111);
    chk3("release_busy_a", busy_a, 3'b000);
    chk3("release_dropped_a", dropped_a, 3'b000);

    // Rising edge on channel 0: 6 cycles, three edges after the input change.
    sig_a[0] = 1'b0;
    repeat (5) tick();
    sig_a[0] = 1'b1;
    push(0, cyc + 3, 6);
    repeat (12) tick();

    sw_a[1] = 1'b1;
    push(1, cyc + 1, 2);
    tick();
    sw_a[1] = 1'b0;
    repeat (5) tick();

    // Channel 2: 32-cycle pulse, refused retrigger, clear and set-wins.
    k = cyc;
    sw_a[2] = 1'b1;
    push(2, k + 1, 32);
    tick();
    sw_a[2] = 1'b0;
    repeat (9) tick();
    sw_a[2] = 1'b1;
    tick();
    sw_a[2] = 1'b0;
    tick();
    chk3("ch2_dropped_set", dropped_a, 3'b100);
    chk3("ch2_busy", busy_a, 3'b100);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    tick();
    chk3("ch2_dropped_clr", dropped_a, 3'b000);
    sw_a[2] = 1'b1; clr_a = 1'b1;
    tick();
    sw_a[2] = 1'b0; clr_a = 1'b0;
    tick();
    chk3("ch2_set_wins", dropped_a, 3'b100);
    repeat (25) tick();
    chk3("ch2_idle_after", busy_a, 3'b000);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    tick();
    chk3("ch2_dropped_final", dropped_a, 3'b000);

    // dut_b channel 0 retrigger: triggers 4 cycles apart give a 10-cycle pulse.
    sw_b[0] = 1'b1;
    push(3, cyc + 1, 10);
    tick();
    sw_b[0] = 1'b0;
    repeat (3) tick();
    sw_b[0] = 1'b1;
    tick();
    sw_b[0] = 1'b0;
    repeat (20) tick();
    chk3("retrig_no_drop", dropped_b, 3'b000);

    // dut_b channel 1 holdoff of 4: triggers at holdoff offsets 0 and 3 refused, 4 accepted.
    k = cyc;
    sw_b[1] = 1'b1;
    push(4, k + 1, 2);
    tick();
    sw_b[1] = 1'b0;
    repeat (2) tick();
    sw_b[1] = 1'b1;
    tick();
    sw_b[1] = 1'b0;
    repeat (2) tick();
    sw_b[1] = 1'b1;
    tick();
    push(4, k + 8, 2);
    tick();
    sw_b[1] = 1'b0;
    tick();
    chk3("holdoff_dropped", dropped_b, 3'b010);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    tick();
    chk3("holdoff_clr", dropped_b, 3'b000);
    repeat (10) tick();

    // dut_b channel 1 both edges, active-high output.
    sig_b[1] = 1'b1;
    push(4, cyc + 3, 2);
    repeat (20) tick();
    sig_b[1] = 1'b0;
    push(4, cyc + 3, 2);
    repeat (20) tick();
    chk3("edges_no_drop", dropped_b, 3'b000);

    // Reset mid-pulse: output drops asynchronously.
    mon_en[4] = 1'b0;
    sig_b[1] = 1'b1;
    repeat (3) tick();
    chk3("mid_pulse_active", pulse_out_b, 3'b111);
    rst_n = 1'b0;
    #1;
    chk3("mid_reset_pulse_b", pulse_out_b, 3'b101);
    chk3("mid_reset_busy_b", busy_b, 3'b000);
    chk3("mid_reset_pulse_a", pulse_out_a, 3'b111);
    repeat (2) tick();
    mon_en = '0;

    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pulses_missing: got %0d unmatched, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
